lfsr_checker: RTL
=================

Name: lfsr_checker

Overview:
- Downstream consumer of the 4-bit LFSR stage (feedback `next = {q[2:0], q[3]^q[1]}`).
- Receives one 4-bit word per valid cycle and self-synchronises to the stream.
- Declares lock after a run of correct predictions, then flywheels and counts errors.
- Drops lock after a configurable run of consecutive mismatches; used as the built-in self-test monitor on the LFSR output.

Parameters:
- LOCK_CNT, 3: consecutive correct predictions after the seed word required to assert lock (≥1).
- UNLOCK_CNT, 2: consecutive mismatches while locked that force loss of lock (≥1).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-low reset (reset==0 at a rising edge resets the block).
- valid_i, input, 1: data_i holds a sample this cycle.
- data_i, input, 4: LFSR word from the upstream stage.
- clear_i, input, 1: synchronous clear of err_cnt_o only.
- locked_o, output, 1: registered; high while in LOCKED.
- err_o, output, 1: registered one-cycle pulse per mismatch while LOCKED.
- zero_o, output, 1: registered one-cycle pulse when an all-zero word arrives in HUNT (illegal LFSR state).
- err_cnt_o, output, ERR_W: saturating count of LOCKED mismatches.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to HUNT; expected word, run counter and miss counter clear to 0.
  - locked_o=0, err_o=0, zero_o=0, err_cnt_o=0.
  - Reset mid-operation behaves identically, with no residual lock.
- Internal function: nxt(x) = {x[2:0], x[3]^x[1]}.
  - Sequence from 4'h1 (period 6): 1,2,5,A,4,8,1…
- Cycles with valid_i=0:
  - No state, expectation or counter change.
  - err_o and zero_o are 0 the following cycle.
- HUNT, on valid_i:
  - data_i==0: zero_o=1 next cycle; stay in HUNT.
  - Otherwise: exp<=nxt(data_i), run<=0, go to VERIFY.
- VERIFY, on valid_i:
  - Match (data_i==exp) with run+1==LOCK_CNT: go to LOCKED; locked_o rises on the same edge; exp<=nxt(data_i).
  - Match otherwise: run<=run+1, exp<=nxt(data_i).
  - Mismatch with data_i!=0: reseed, exp<=nxt(data_i), run<=0, stay in VERIFY.
  - Mismatch with data_i==0: go to HUNT; zero_o=0.
  - No error counting in VERIFY.
- LOCKED, on valid_i (flywheel: exp<=nxt(exp) always; never reseeds from data):
  - Match: miss<=0.
  - Mismatch: err_o=1 next cycle; err_cnt_o increments, saturating at 2^ERR_W−1; miss<=miss+1.
  - If miss+1==UNLOCK_CNT: go to HUNT; locked_o falls on that edge; the err_o pulse for that word is still issued.
- clear_i:
  - Sets err_cnt_o<=0.
  - If it coincides with a counted error, clear wins: err_cnt_o=0, but err_o still pulses.
- Latency: every output reflects the valid word sampled at the previous edge (one cycle).
- No combinational path from inputs to outputs.

Test Plan:
- Lock, LOCK_CNT=3: release reset; feed 1,2,5,A back-to-back. locked_o=1 the cycle after A is sampled; err_cnt_o=0. Continue 4,8,1,2 → locked_o stays 1, err_o never pulses.
- Single error: locked, feed F in place of 4, then 8,1. err_o pulses once, one cycle after F; err_cnt_o=1; locked_o stays 1 (flywheel predicts 8 correctly).
- Unlock, UNLOCK_CNT=2: locked and expecting 4; feed 3,3. Two err_o pulses; err_cnt_o=2; locked_o=0 after the second. Then feed 2,5,A,4 → relock after 4.
- Zero handling: in HUNT feed 0,0,1,2,5,A. zero_o pulses twice; locked_o=1 after A. Separately, a 0 arriving in VERIFY returns to HUNT with no zero_o.
- Saturation and clear, ERR_W=2: locked; inject 5 non-consecutive errors, each followed by a good word. err_cnt_o=3 (saturated). Assert clear_i on the next error cycle → err_cnt_o=0, err_o pulses.
- Valid gaps and reset: insert 3 idle cycles between each word of 1,2,5,A → lock still occurs with no spurious pulses. Then drive reset=0 for one edge while locked → locked_o=0, err_cnt_o=0; the next word is treated as a HUNT seed.

Source files
------------

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for the 4-bit LFSR stage stream
module lfsr_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [3:0]       data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic             zero_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // run counts 0..LOCK_CNT-1, miss counts 0..UNLOCK_CNT-1
    localparam int RUN_W  = (LOCK_CNT > 1)   ? $clog2(LOCK_CNT)   : 1;
    localparam int MISS_W = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    logic [1:0]        state;
    logic [3:0]        exp_word;
    logic [RUN_W-1:0]  run;
    logic [MISS_W-1:0] miss;

    // Successor of a word in the upstream LFSR sequence
    function automatic logic [3:0] nxt(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[1]};
    endfunction

    // Hunt/verify/locked tracking, error pulses and the saturating error counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_HUNT;
            exp_word  <= 4'h0;
            run       <= '0;
            miss      <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            zero_o    <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o  <= 1'b0;
            zero_o <= 1'b0;
            if (valid_i) begin
                case (state)
                    ST_HUNT: begin
                        if (data_i == 4'h0) begin
                            // all-zero is a dead LFSR state; cannot seed from it
                            zero_o <= 1'b1;
                        end else begin
                            exp_word <= nxt(data_i);
                            run      <= '0;
                            state    <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (data_i == exp_word) begin
                            exp_word <= nxt(data_i);
                            if (run == RUN_LAST) begin
                                state    <= ST_LOCKED;
                                locked_o <= 1'b1;
                                miss     <= '0;
                            end else begin
                                run <= run + RUN_W'(1);
                            end
                        end else if (data_i != 4'h0) begin
                            // reseed from the offending word and restart the run
                            exp_word <= nxt(data_i);
                            run      <= '0;
                        end else begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_LOCKED: begin
                        // flywheel: prediction advances from itself, never from data
                        exp_word <= nxt(exp_word);
                        if (data_i == exp_word) begin
                            miss <= '0;
                        end else begin
                            err_o <= 1'b1;
                            if (err_cnt_o != ERR_MAX) begin
                                err_cnt_o <= err_cnt_o + ERR_W'(1);
                            end
                            if (miss == MISS_LAST) begin
                                state    <= ST_HUNT;
                                locked_o <= 1'b0;
                                miss     <= '0;
                            end else begin
                                miss <= miss + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= ST_HUNT;
                        locked_o <= 1'b0;
                    end
                endcase
            end
            // clear takes priority over a same-cycle increment
            if (clear_i) begin
                err_cnt_o <= '0;
            end
        end
    end

endmodule
